mxint_block_exp_ctrl: RTL

MXINT_BLOCK_EXP_CTRL -- requirements
Module: mxint_block_exp_ctrl

---
 rtl/mxint_block_exp_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mxint_block_exp_ctrl.sv
// mxint_block_exp_ctrl
//   Collects BLOCK_BEATS input beats into a local buffer. While it does so it
//   tracks the largest per-beat magnitude exponent. It then replays the beats
//   unmodified, with that exponent shared across the whole block. Filling and
//   draining never overlap, so a block is fully replayed before the next one
//   is accepted.
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   data_in[]       : input beat, IN_SIZE two's-complement lanes
//   data_in_valid   : input beat valid
//   data_in_ready   : block can take a beat (high only while filling)
//   data_out[]      : replayed beat (zero when not valid)
//   exp_out         : shared block exponent (zero when not valid)
//   data_out_last   : final beat of the block
//   data_out_valid  : output beat valid (high only while draining)
//   data_out_ready  : downstream accept
module mxint_block_exp_ctrl #(
  parameter int IN_SIZE     = 2,
  parameter int IN_WIDTH    = 32,
  parameter int BLOCK_BEATS = 4,
  parameter int EXP_WIDTH   = $clog2(IN_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in [0:IN_SIZE-1],
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [IN_WIDTH-1:0]  data_out [0:IN_SIZE-1],
  output logic [EXP_WIDTH-1:0] exp_out,
  output logic                 data_out_last,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  localparam int CNT_W = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(BLOCK_BEATS - 1);
  localparam logic [IN_WIDTH-1:0] ONE      = IN_WIDTH'(1);

  localparam logic S_FILL  = 1'b0;
  localparam logic S_DRAIN = 1'b1;

  logic                 r_state;
  logic [CNT_W-1:0]     r_wr_cnt;
  logic [CNT_W-1:0]     r_rd_cnt;
  logic [EXP_WIDTH-1:0] r_max_exp;
  logic [IN_WIDTH-1:0]  r_buf [0:BLOCK_BEATS-1][0:IN_SIZE-1];

  logic [IN_WIDTH-1:0]  w_abs [0:IN_SIZE-1];
  logic [IN_WIDTH-1:0]  w_or;
  logic [EXP_WIDTH-1:0] w_beat_exp;
  logic                 w_in_fire;
  logic                 w_out_fire;

  assign data_in_ready  = (r_state == S_FILL);
  assign data_out_valid = (r_state == S_DRAIN);
  assign w_in_fire      = data_in_ready && data_in_valid;
  assign w_out_fire     = data_out_valid && data_out_ready;

  // Beat exponent: the position of the top set bit of the OR of the lane
  // magnitudes. The most-negative value wraps to itself, so only its MSB is
  // set and the result is IN_WIDTH.
  always_comb begin
    w_or       = '0;
    w_beat_exp = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      w_abs[i] = data_in[i][IN_WIDTH-1] ? (~data_in[i] + ONE) : data_in[i];
      w_or     = w_or | w_abs[i];
    end
    for (int b = 0; b < IN_WIDTH; b++)
      if (w_or[b]) w_beat_exp = EXP_WIDTH'(b + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FILL;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_max_exp <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_in_fire) begin
            // The final beat's exponent is folded in on the same edge.
            if (w_beat_exp > r_max_exp) r_max_exp <= w_beat_exp;
            if (r_wr_cnt == LAST_CNT) begin
              r_wr_cnt <= '0;
              r_state  <= S_DRAIN;
            end else begin
              r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (w_out_fire) begin
            if (r_rd_cnt == LAST_CNT) begin
              r_rd_cnt  <= '0;
              r_max_exp <= '0;
              r_state   <= S_FILL;
            end else begin
              r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  // The buffer has no reset. Stale contents are never visible, because the
  // counters restart on reset and a slot is always written before it is read.
  always_ff @(posedge clk) begin
    if (w_in_fire) r_buf[r_wr_cnt] <= data_in;
  end

  always_comb begin
    for (int i = 0; i < IN_SIZE; i++)
      data_out[i] = data_out_valid ? r_buf[r_rd_cnt][i] : '0;
    exp_out       = data_out_valid ? r_max_exp : '0;
    data_out_last = data_out_valid && (r_rd_cnt == LAST_CNT);
  end

endmodule
